// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester Alu arbiter: Alu oper codes, Alu port structs,
// arbiter response struct and buffer state encoding.
package alu_arbiter_pkg;

    localparam int ALU_DATA_WIDTH  = 32;
    localparam int ALU_OPER_W      = 4;
    localparam int ALU_SHAMT_W     = $clog2(ALU_DATA_WIDTH);
    localparam int ALU_ARB_NUM_REQ = 2;

    typedef enum logic [ALU_OPER_W-1:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluLsl  = 4'd5,
        AluLsr  = 4'd6,
        AluAsr  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9
    } AluOper;

    typedef struct packed {
        AluOper                    oper;
        logic [ALU_DATA_WIDTH-1:0] a;
        logic [ALU_DATA_WIDTH-1:0] b;
    } PortIn_AluReq;

    // The Alu input port carries exactly one request's fields.
    typedef PortIn_AluReq PortIn_Alu;

    typedef struct packed {
        logic [ALU_DATA_WIDTH-1:0] data;
    } PortOut_Alu;

    typedef struct packed {
        logic                      id;
        logic [ALU_DATA_WIDTH-1:0] data;
    } PortOut_AluRsp;

    typedef enum logic {
        ArbEmpty = 1'b0,
        ArbFull  = 1'b1
    } AluArbState;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between the requesters/consumer (master) and the Alu arbiter (slave).
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
);
    // Handshake: a request transfers in a cycle where req_valid[i] & req_ready[i];
    // req_* must hold stable while req_valid[i]=1 and not yet accepted. A result
    // leaves the buffer in a cycle where rsp_valid & rsp_ready.
    logic [ALU_ARB_NUM_REQ-1:0]                 req_valid;
    logic [ALU_ARB_NUM_REQ-1:0]                 req_ready;
    logic [ALU_ARB_NUM_REQ-1:0][ALU_OPER_W-1:0] req_oper;
    logic [ALU_ARB_NUM_REQ-1:0][DATA_WIDTH-1:0] req_a;
    logic [ALU_ARB_NUM_REQ-1:0][DATA_WIDTH-1:0] req_b;
    logic                                       rsp_valid;
    logic                                       rsp_id;
    logic [DATA_WIDTH-1:0]                      rsp_data;
    logic                                       rsp_ready;

    modport master (
        output req_valid, req_oper, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_oper, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/alu.sv
// Combinational Alu: one result per oper code, unknown codes produce zero.
module alu
    import alu_arbiter_pkg::*;
(
    input  PortIn_Alu  i_in,
    output PortOut_Alu o_out
);

    logic [ALU_SHAMT_W-1:0] w_shamt;

    assign w_shamt = i_in.b[ALU_SHAMT_W-1:0];

    always_comb begin
        o_out.data = '0;
        case (i_in.oper)
            AluAdd:  o_out.data = i_in.a + i_in.b;
            AluSub:  o_out.data = i_in.a - i_in.b;
            AluAnd:  o_out.data = i_in.a & i_in.b;
            AluOr:   o_out.data = i_in.a | i_in.b;
            AluXor:  o_out.data = i_in.a ^ i_in.b;
            AluLsl:  o_out.data = i_in.a << w_shamt;
            AluLsr:  o_out.data = i_in.a >> w_shamt;
            AluAsr:  o_out.data = $unsigned($signed(i_in.a) >>> w_shamt);
            AluSlt:  o_out.data = ALU_DATA_WIDTH'($signed(i_in.a) < $signed(i_in.b));
            AluSltu: o_out.data = ALU_DATA_WIDTH'(i_in.a < i_in.b);
            default: o_out.data = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb_pick.sv
// One-hot grant selection for two requesters. ALU_ARB_ROUND_ROBIN_EN selects
// round-robin on contention; without it req 0 has fixed priority.
module alu_arb_pick
    import alu_arbiter_pkg::*;
(
    input  logic [ALU_ARB_NUM_REQ-1:0] i_req_valid,
    input  logic                       i_last_grant,
    input  logic                       i_can_accept,
    output logic [ALU_ARB_NUM_REQ-1:0] o_grant
);

`ifndef ALU_ARB_ROUND_ROBIN_EN
    // Last grant is tracked by the arbiter either way; fixed priority ignores it.
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;
`endif

    always_comb begin
        o_grant = '0;
        if (i_can_accept) begin
            if (i_req_valid == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
                o_grant = i_last_grant ? 2'b01 : 2'b10;
`else
                o_grant = 2'b01;
`endif
            end else begin
                o_grant = i_req_valid;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one Alu between two requesters and registers each result with its
// requester ID in a one-entry buffer. Arbitration mode: ALU_ARB_ROUND_ROBIN_EN.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    alu_arbiter_if.slave io_bus,
    output AluArbState   o_state
);

    AluArbState                 r_state;
    AluArbState                 w_state_nxt;
    logic                       r_last_grant;
    PortOut_AluRsp              r_rsp;
    logic                       w_can_accept;
    logic [ALU_ARB_NUM_REQ-1:0] w_grant;
    logic                       w_xfer;
    logic                       w_sel;
    PortIn_Alu                  w_alu_in;
    PortOut_Alu                 w_alu_out;

    // Reset blocks acceptance so an in-flight grant is dropped, not captured.
    assign w_can_accept = !i_rst && ((r_state == ArbEmpty) || io_bus.rsp_ready);

    alu_arb_pick u_pick (
        .i_req_valid  (io_bus.req_valid),
        .i_last_grant (r_last_grant),
        .i_can_accept (w_can_accept),
        .o_grant      (w_grant)
    );

    assign io_bus.req_ready = {ALU_ARB_NUM_REQ{w_can_accept}} & w_grant;
    assign w_xfer           = |(io_bus.req_valid & io_bus.req_ready);
    // No grant leaves the select at req 0; the Alu output is then not captured.
    assign w_sel            = w_grant[1];

    always_comb begin
        w_alu_in.oper = AluOper'(io_bus.req_oper[w_sel]);
        w_alu_in.a    = io_bus.req_a[w_sel];
        w_alu_in.b    = io_bus.req_b[w_sel];
    end

    alu u_alu (
        .i_in  (w_alu_in),
        .o_out (w_alu_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ArbEmpty: if (w_xfer) w_state_nxt = ArbFull;
            ArbFull:  if (io_bus.rsp_ready && !w_xfer) w_state_nxt = ArbEmpty;
            default:  w_state_nxt = ArbEmpty;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ArbEmpty;
            r_last_grant <= 1'b1;
            r_rsp        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_rsp.id     <= w_sel;
                r_rsp.data   <= w_alu_out.data;
                r_last_grant <= w_sel;
            end
        end
    end

    assign io_bus.rsp_valid = (r_state == ArbFull);
    assign io_bus.rsp_id    = r_rsp.id;
    assign io_bus.rsp_data  = r_rsp.data;
    assign o_state          = r_state;

endmodule
